// File: rtl/fb_pkg.sv
// Shared definitions for the rectangle-fill accelerator: frame geometry,
// bus register map, FSM encoding and frame-buffer address packing.
package fb_pkg;

    // Frame geometry (160x120 monochrome)
    localparam logic [7:0] X_MAX     = 8'd159;
    localparam logic [6:0] Y_MAX     = 7'd119;
    localparam int         FB_ADDR_W = 15;

    // Bus register map, offsets from the block's base address
    localparam int         NUM_REGS   = 7;
    localparam int         REG_OFF_W  = 3;
    localparam logic [2:0] REG_X0     = 3'd0;
    localparam logic [2:0] REG_Y0     = 3'd1;
    localparam logic [2:0] REG_X1     = 3'd2;
    localparam logic [2:0] REG_Y1     = 3'd3;
    localparam logic [2:0] REG_COLOUR = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_FINISH
    } state_e;

    // Frame-buffer address is row-major: {y[6:0], x[7:0]}
    function automatic logic [FB_ADDR_W-1:0] pack_addr(input logic [6:0] y,
                                                      input logic [7:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/bus_reg_port.sv
// Generic shared-bus slave port: decodes a contiguous window of owned
// addresses, registers read data and drives the bus one cycle after a read
// address is presented, for as long as that read stays on the bus.
module bus_reg_port #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         NUM_REGS  = 1,
    parameter int         OFF_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       bus_addr,
    inout  wire  [7:0]       bus_data,
    input  logic             bus_we,
    input  logic [7:0]       rd_data,
    output logic             hit,
    output logic [OFF_W-1:0] offset,
    output logic             wr_en,
    output logic [7:0]       wr_data
);

    logic [7:0] offset_full;
    logic       rd_hit;
    logic [7:0] rd_d, rd_q;
    logic       drive_d, drive_q;

    assign offset_full = bus_addr - BASE_ADDR;
    assign hit         = (offset_full < 8'(NUM_REGS));
    assign offset      = offset_full[OFF_W-1:0];
    assign rd_hit      = hit && !bus_we;
    assign wr_en       = hit && bus_we;
    assign wr_data     = bus_data;

    // Capture read data on a read match; remember that a read was presented
    // NOTE: every signal written here gets its value first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        rd_d    = rd_q;
        drive_d = rd_hit;
        if (rd_hit) begin
            rd_d = rd_data;
        end
    end

    // Read-data and drive-enable registers
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= 8'h00;
            drive_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            drive_q <= drive_d;
        end
    end

    assign bus_data = (drive_q && rd_hit) ? rd_q : {8{1'bz}};

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill drawing accelerator: the CPU programs a rectangle and colour
// over the shared bus, then one pixel per clock is written into the frame
// buffer until the clipped rectangle is done or the fill is aborted.
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hB8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [7:0]           BUS_ADDR,
    inout  wire  [7:0]           BUS_DATA,
    input  logic                 BUS_WE,
    output logic [FB_ADDR_W-1:0] FB_ADDR,
    output logic                 FB_DATA,
    output logic                 FB_WE,
    output logic                 BUSY,
    output logic                 DONE
);

    logic                 bus_hit;
    logic [REG_OFF_W-1:0] reg_off;
    logic                 wr_en;
    logic [7:0]           wr_data;
    logic [7:0]           rd_data;

    logic [7:0] x0_d, x0_q, y0_d, y0_q, x1_d, x1_q, y1_d, y1_q;
    logic       colour_d, colour_q;
    logic       last_aborted_d, last_aborted_q;
    state_e     state_d, state_q;
    logic [7:0] x_d, x_q, xe_d, xe_q;
    logic [6:0] y_d, y_q, ye_d, ye_q;

    logic       start_wr, abort_wr;
    logic [7:0] xe_clip;
    logic [6:0] ye_clip;
    logic       rect_empty;

    bus_reg_port #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .OFF_W     (REG_OFF_W)
    ) u_port (
        .clk      (CLK),
        .rst      (RESET),
        .bus_addr (BUS_ADDR),
        .bus_data (BUS_DATA),
        .bus_we   (BUS_WE),
        .rd_data  (rd_data),
        .hit      (bus_hit),
        .offset   (reg_off),
        .wr_en    (wr_en),
        .wr_data  (wr_data)
    );

    assign BUSY     = (state_q != ST_IDLE);
    assign start_wr = wr_en && (reg_off == REG_CTRL) && wr_data[0];
    assign abort_wr = wr_en && (reg_off == REG_CTRL) && wr_data[1];

    // Clip the far corner to the screen; Y0 beyond 127 always ends up empty
    assign xe_clip    = (x1_q > X_MAX) ? X_MAX : x1_q;
    assign ye_clip    = (y1_q > {1'b0, Y_MAX}) ? Y_MAX : y1_q[6:0];
    assign rect_empty = (x0_q > xe_clip) || (y0_q > {1'b0, ye_clip});

    // Read mux for the owned registers; CTRL is write-only and reads 0
    always_comb begin
        rd_data = 8'h00;
        case (reg_off)
            REG_X0:     rd_data = x0_q;
            REG_Y0:     rd_data = y0_q;
            REG_X1:     rd_data = x1_q;
            REG_Y1:     rd_data = y1_q;
            REG_COLOUR: rd_data = {7'b0, colour_q};
            REG_STATUS: rd_data = {6'b0, last_aborted_q, BUSY};
            default:    rd_data = 8'h00;
        endcase
        if (!bus_hit) begin
            rd_data = 8'h00;
        end
    end

    // Parameter register writes, frozen while a fill is in progress
    always_comb begin
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        colour_d = colour_q;
        if (wr_en && !BUSY) begin
            case (reg_off)
                REG_X0:     x0_d     = wr_data;
                REG_Y0:     y0_d     = wr_data;
                REG_X1:     x1_d     = wr_data;
                REG_Y1:     y1_d     = wr_data;
                REG_COLOUR: colour_d = wr_data[0];
                default:    ;
            endcase
        end
    end

    // Fill sequencer: start, clip, raster the rectangle row-major, finish
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        xe_d           = xe_q;
        ye_d           = ye_q;
        last_aborted_d = last_aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (start_wr && !abort_wr) begin
                    state_d        = ST_SETUP;
                    last_aborted_d = 1'b0;
                end
            end
            ST_SETUP: begin
                xe_d    = xe_clip;
                ye_d    = ye_clip;
                x_d     = x0_q;
                y_d     = y0_q[6:0];
                state_d = rect_empty ? ST_FINISH : ST_RUN;
            end
            ST_RUN: begin
                if (abort_wr) begin
                    state_d        = ST_FINISH;
                    last_aborted_d = 1'b1;
                end else if (x_q == xe_q) begin
                    if (y_q == ye_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        x_d = x0_q;
                        y_d = y_q + 7'd1;
                    end
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registers; reset aborts any fill immediately
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x0_q           <= 8'h00;
            y0_q           <= 8'h00;
            x1_q           <= 8'h00;
            y1_q           <= 8'h00;
            colour_q       <= 1'b0;
            last_aborted_q <= 1'b0;
            state_q        <= ST_IDLE;
            x_q            <= 8'h00;
            y_q            <= 7'h00;
            xe_q           <= 8'h00;
            ye_q           <= 7'h00;
        end else begin
            x0_q           <= x0_d;
            y0_q           <= y0_d;
            x1_q           <= x1_d;
            y1_q           <= y1_d;
            colour_q       <= colour_d;
            last_aborted_q <= last_aborted_d;
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            xe_q           <= xe_d;
            ye_q           <= ye_d;
        end
    end

    // Frame-buffer write port, quiet outside RUN
    always_comb begin
        FB_WE   = (state_q == ST_RUN);
        FB_DATA = 1'b0;
        FB_ADDR = '0;
        if (state_q == ST_RUN) begin
            FB_DATA = colour_q;
            FB_ADDR = pack_addr(y_q, x_q);
        end
        DONE = (state_q == ST_FINISH);
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: table of rectangles with a pixel
// scoreboard, plus hand-written abort and reset-during-fill sequences.
module tb_fb_rect_fill;

    localparam logic [7:0] BASE = 8'hB8;
    localparam logic [2:0] O_X0 = 3'd0, O_Y0 = 3'd1, O_X1 = 3'd2, O_Y1 = 3'd3;
    localparam logic [2:0] O_COL = 3'd4, O_CTRL = 3'd5, O_STAT = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bus_addr;
    logic        bus_we;
    logic [7:0]  tb_data;
    logic        tb_drive;
    wire  [7:0]  bus_data;
    logic [14:0] fb_addr;
    logic        fb_data, fb_we, busy, done;

    assign bus_data = tb_drive ? tb_data : {8{1'bz}};

    fb_rect_fill #(.BASE_ADDR(BASE)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .BUS_ADDR (bus_addr),
        .BUS_DATA (bus_data),
        .BUS_WE   (bus_we),
        .FB_ADDR  (fb_addr),
        .FB_DATA  (fb_data),
        .FB_WE    (fb_we),
        .BUSY     (busy),
        .DONE     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Pixel scoreboard
    typedef struct packed {
        logic [14:0] addr;
        logic        data;
    } pix_t;
    pix_t exp_q[$];
    int   fb_we_cnt = 0, busy_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("fb_we_in_reset", {31'b0, fb_we}, 32'd0);
        end else begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (fb_we) begin
                fb_we_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pixel: got addr 0x%0h with no pixel expected", fb_addr);
                end else begin
                    pix_t p;
                    p = exp_q.pop_front();
                    check("pix_addr", {17'b0, fb_addr}, {17'b0, p.addr});
                    check("pix_data", {31'b0, fb_data}, {31'b0, p.data});
                end
            end
        end
    end

    // Reference model: clip and raster the rectangle into the scoreboard
    task automatic push_expected(input int x0, input int y0, input int x1, input int y1,
                                 input logic c);
        int xe, ye;
        pix_t p;
        xe = (x1 > 159) ? 159 : x1;
        ye = (y1 > 119) ? 119 : y1;
        for (int y = y0; y <= ye; y++) begin
            for (int x = x0; x <= xe; x++) begin
                p.addr = {7'(y), 8'(x)};
                p.data = c;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
        @(posedge clk); #2;
        bus_addr = BASE + 8'(off);
        tb_data  = d;
        tb_drive = 1'b1;
        bus_we   = 1'b1;
        @(posedge clk); #2;
        bus_we   = 1'b0;
        tb_drive = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [7:0] d);
        @(posedge clk); #2;
        bus_addr = BASE + 8'(off);
        bus_we   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d = bus_data;
        bus_addr = 8'h00;
    endtask

    task automatic clear_counts();
        fb_we_cnt = 0;
        busy_cnt  = 0;
        done_cnt  = 0;
    endtask

    task automatic program_rect(input logic [7:0] x0, input logic [7:0] y0,
                                input logic [7:0] x1, input logic [7:0] y1, input logic c);
        bus_write(O_X0, x0);
        bus_write(O_Y0, y0);
        bus_write(O_X1, x1);
        bus_write(O_Y1, y1);
        bus_write(O_COL, {7'b1111111, c});
    endtask

    // Wait (bounded) for DONE; returns negedges counted since the call
    task automatic wait_done(input string name, input int limit, output int k);
        k = 0;
        while (k < limit) begin
            @(negedge clk);
            k++;
            if (done) break;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s_timeout: DONE not seen within %0d cycles", name, limit);
        end
    endtask

    task automatic run_fill(input string name, input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] x1, input logic [7:0] y1, input logic c,
                            input int exp_px, input int exp_busy);
        int k;
        logic [7:0] st;
        program_rect(x0, y0, x1, y1, c);
        push_expected(int'(x0), int'(y0), int'(x1), int'(y1), c);
        clear_counts();
        bus_write(O_CTRL, 8'h01);
        @(negedge clk);
        check({name, "_setup_busy"}, {31'b0, busy}, 32'd1);
        check({name, "_setup_fb_we"}, {31'b0, fb_we}, 32'd0);
        check({name, "_setup_done"}, {31'b0, done}, 32'd0);
        wait_done(name, 25000, k);
        check({name, "_done_at"}, k + 1, exp_busy);
        repeat (3) @(posedge clk);
        #2;
        check({name, "_pixels"}, fb_we_cnt, exp_px);
        check({name, "_busy_cycles"}, busy_cnt, exp_busy);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
        bus_read(O_STAT, st);
        check({name, "_status"}, {24'b0, st}, 32'h00);
    endtask

    typedef struct {
        string      name;
        logic [7:0] x0, y0, x1, y1;
        logic       c;
        int         exp_px;
        int         exp_busy;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] rd;
    int         k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"basic_3x2",   8'd2,   8'd3,   8'd4,   8'd4,   1'b1, 6, 8};
        vecs[1] = '{"clip_2x2",    8'd158, 8'd118, 8'd200, 8'd255, 1'b1, 4, 6};
        vecs[2] = '{"empty_x",     8'd10,  8'd7,   8'd5,   8'd20,  1'b1, 0, 2};
        vecs[3] = '{"empty_y0big", 8'd0,   8'd130, 8'd3,   8'd255, 1'b1, 0, 2};
        vecs[4] = '{"corner_1px",  8'd159, 8'd119, 8'd159, 8'd119, 1'b0, 1, 3};
        vecs[5] = '{"column_1x3",  8'd5,   8'd0,   8'd5,   8'd2,   1'b0, 3, 5};

        rst = 1'b1; bus_addr = 8'h00; bus_we = 1'b0; tb_data = 8'h00; tb_drive = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_fb_addr", {17'b0, fb_addr}, 32'd0);
        check("reset_fb_data", {31'b0, fb_data}, 32'd0);
        rst = 1'b0;
        bus_read(O_STAT, rd);
        check("reset_status", {24'b0, rd}, 32'h00);
        check("reset_fb_we_total", fb_we_cnt, 0);

        // Table-driven rectangles
        for (int i = 0; i < 6; i++) begin
            run_fill(vecs[i].name, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
                     vecs[i].c, vecs[i].exp_px, vecs[i].exp_busy);
        end
        bus_read(O_X1, rd);
        check("readback_x1", {24'b0, rd}, 32'd5);
        bus_read(O_COL, rd);
        check("readback_colour_bit0_only", {24'b0, rd}, 32'h00);
        bus_read(O_CTRL, rd);
        check("readback_ctrl_zero", {24'b0, rd}, 32'h00);

        // Full-screen fill aborted after 100 pixels, with ignored writes while busy
        program_rect(8'd0, 8'd0, 8'd159, 8'd119, 1'b1);
        push_expected(0, 0, 159, 119, 1'b1);
        clear_counts();
        bus_write(O_CTRL, 8'h01);
        bus_read(O_STAT, rd);
        check("abort_status_busy", {24'b0, rd}, 32'h01);
        bus_write(O_X0, 8'd50);
        bus_write(O_CTRL, 8'h01);
        k = 0;
        while (fb_we_cnt < 100 && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        check("abort_reach_100", fb_we_cnt, 100);
        bus_write(O_CTRL, 8'h02);
        wait_done("abort", 1000, k);
        repeat (3) @(posedge clk);
        #2;
        check("abort_pixels", fb_we_cnt, 101);
        check("abort_done_pulses", done_cnt, 1);
        exp_q.delete();
        bus_read(O_STAT, rd);
        check("abort_status", {24'b0, rd}, 32'h02);
        bus_read(O_X0, rd);
        check("abort_x0_held", {24'b0, rd}, 32'h00);

        // A fresh start clears last_aborted (run_fill checks STATUS = 0)
        run_fill("after_abort", 8'd20, 8'd30, 8'd21, 8'd30, 1'b1, 2, 4);

        // Reset in the middle of a 10x10 fill
        program_rect(8'd0, 8'd0, 8'd9, 8'd9, 1'b1);
        push_expected(0, 0, 9, 9, 1'b1);
        clear_counts();
        bus_write(O_CTRL, 8'h01);
        k = 0;
        while (fb_we_cnt < 20 && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        check("rst_mid_reach_20", fb_we_cnt, 20);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_fb_we", {31'b0, fb_we}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_pixels", fb_we_cnt, 20);
        exp_q.delete();
        bus_read(O_X1, rd);
        check("rst_mid_x1_cleared", {24'b0, rd}, 32'h00);
        run_fill("after_reset", 8'd2, 8'd3, 8'd4, 8'd4, 1'b1, 6, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
